// File: rtl/axis_frame_feeder.sv
// Stimulus feeder for the NN core's AXI-Stream ports. It buffers input words in a FIFO,
// emits fixed-length frames with a generated last flag, and sinks and checks the class results.
module axis_frame_feeder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RES_W       = 4,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned FRAME_WORDS = 196,
    parameter int unsigned MAX_OUT     = 4
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              m_axis_valid,
    output logic [DATA_W-1:0] m_axis_data,
    output logic              m_axis_last,
    input  logic              m_axis_ready,
    input  logic              s_axis_valid,
    input  logic [RES_W-1:0]  s_axis_data,
    input  logic              s_axis_last,
    output logic              s_axis_ready,
    output logic [RES_W-1:0]  result,
    output logic              result_valid,
    output logic              frame_done,
    output logic              proto_err
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [IDX_W-1:0]  r_idx;
    logic [OUT_W-1:0]  r_out;
    logic [RES_W-1:0]  r_result;
    logic              r_result_valid;
    logic              r_frame_done;
    logic              r_proto_err;

    logic              w_full;
    logic              w_push;
    logic              w_load;
    logic              w_hs_out;
    logic              w_last_hs;
    logic              w_res_hs;
    logic              w_gate_open;
    logic              w_err_set;
    logic [OUT_W-1:0]  w_out_d;
    logic [CNT_W-1:0]  w_count_d;

    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push       = wr_en && !w_full;
    assign w_hs_out     = r_valid && m_axis_ready;
    assign w_last_hs    = w_hs_out && r_last;
    assign s_axis_ready = !axi_reset;
    assign w_res_hs     = s_axis_valid && s_axis_ready;

    always_comb begin
        w_out_d   = r_out;
        w_err_set = w_res_hs && !s_axis_last;
        unique case ({w_last_hs, w_res_hs})
            2'b10: w_out_d = r_out + OUT_W'(1);
            2'b01: begin
                if (r_out != '0) begin
                    w_out_d = r_out - OUT_W'(1);
                end else begin
                    w_err_set = 1'b1;
                end
            end
            default: w_out_d = r_out;
        endcase
    end

    // Gate on the post-update credit so a frame cannot start in the cycle the last credit is used.
    assign w_gate_open = !((r_idx == '0) && (w_out_d == OUT_W'(MAX_OUT)));
    assign w_load      = (r_count != '0) && (!r_valid || w_hs_out) && w_gate_open;

    always_comb begin
        w_count_d = r_count;
        if (w_push && !w_load) begin
            w_count_d = r_count + CNT_W'(1);
        end else if (!w_push && w_load) begin
            w_count_d = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge axi_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_valid        <= 1'b0;
            r_data         <= '0;
            r_last         <= 1'b0;
            r_idx          <= '0;
            r_out          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_proto_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_d;
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= r_mem[r_rd_ptr];
                r_last  <= (r_idx == IDX_W'(FRAME_WORDS - 1));
                r_idx   <= (r_idx == IDX_W'(FRAME_WORDS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else if (w_hs_out) begin
                r_valid <= 1'b0;
            end
            r_out          <= w_out_d;
            r_frame_done   <= w_last_hs;
            r_result_valid <= w_res_hs;
            if (w_res_hs) begin
                r_result <= s_axis_data;
            end
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign wr_full      = w_full;
    assign m_axis_valid = r_valid;
    assign m_axis_data  = r_data;
    assign m_axis_last  = r_last;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign frame_done   = r_frame_done;
    assign proto_err    = r_proto_err;

endmodule
